// File: rtl/div_seq32.sv
// div_seq32 -- multicycle restoring divider for the DIV instruction.
// Latches A/B on a start pulse and produces quotient on lo and remainder on hi,
// one quotient bit per clock. Quotient truncates toward zero and the remainder
// takes the sign of the dividend. A zero divisor finishes at once with div_zero
// and leaves lo/hi untouched.
// Optional feature macro: DIV_UNSIGNED_EN adds the is_unsigned input (DIVU).
module div_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Magnitudes are WIDTH+1 bits so that |INT_MIN| is representable.
  logic [WIDTH:0]  q;         // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0]  rem;       // partial remainder
  logic [WIDTH:0]  dvs;       // divisor magnitude
  logic [CW-1:0]   count;     // iterations still to run
  logic            neg_a;     // dividend was negative (signed op only)
  logic            neg_b;     // divisor was negative (signed op only)

  logic            signed_op;
  logic            neg_a_in;
  logic            neg_b_in;
  logic [WIDTH:0]  a_ext;
  logic [WIDTH:0]  b_ext;
  logic [WIDTH:0]  mag_a;
  logic [WIDTH:0]  mag_b;
  logic [WIDTH:0]  rem_shift;
  logic [WIDTH:0]  rem_sub;
  logic            rem_ge;
  logic [WIDTH:0]  quot_fix;
  logic [WIDTH:0]  rem_fix;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  // Operand magnitudes at acceptance, plus one restoring step and sign fix-up.
  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    neg_a_in  = signed_op & dividend[WIDTH-1];
    neg_b_in  = signed_op & divisor_in[WIDTH-1];
    a_ext     = {neg_a_in, dividend};
    b_ext     = {neg_b_in, divisor_in};
    mag_a     = neg_a_in ? -a_ext : a_ext;
    mag_b     = neg_b_in ? -b_ext : b_ext;
    rem_shift = (rem << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    rem_ge    = (rem_shift >= dvs);
    rem_sub   = rem_shift - dvs;
    quot_fix  = (neg_a ^ neg_b) ? -q : q;
    rem_fix   = neg_a ? -rem : rem;
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor_in == '0) ? ZERO : CALC;
      CALC: if (count == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      ZERO: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy     = (state == CALC) || (state == FIX);
    done     = (state == DONE) || (state == ZERO);
    div_zero = (state == ZERO);
  end

  // Datapath: operand latch, iteration, and result write-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      rem   <= '0;
      dvs   <= '0;
      count <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q     <= mag_a;
            dvs   <= mag_b;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            rem   <= '0;
            count <= CW'(WIDTH);
          end
        end
        CALC: begin
          if (count != '0) begin
            rem   <= rem_ge ? rem_sub : rem_shift;
            q     <= (q << 1) | {{WIDTH{1'b0}}, rem_ge};
            count <= count - 1'b1;
          end
        end
        FIX: begin
          lo <= WIDTH'(quot_fix);
          hi <= WIDTH'(rem_fix);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq32.sv
// tb_div_seq32 -- self-checking bench for div_seq32 (build with DIV_UNSIGNED_EN
// defined to also exercise the unsigned mode).
module tb_div_seq32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_uns = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor_in = '0;
  logic [31:0] lo, hi;
  logic        busy, done, div_zero;

  int tests = 0;
  int fails = 0;

  // Reference state for lo/hi across div-by-zero operations.
  logic [31:0] mdl_lo, mdl_hi;

  always #5 clock = ~clock;

  div_seq32 #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned(is_uns),
`endif
    .start      (start),
    .dividend   (dividend),
    .divisor_in (divisor_in),
    .lo         (lo),
    .hi         (hi),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  // Reference: plain integer division (truncating) and remainder.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic u,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (u) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    qq = sa / sb;
    rr = sa % sb;
    q  = qq[31:0];
    r  = rr[31:0];
  endfunction

  // Issue one operation; report latency (-1 on timeout), results, and done one cycle later.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                        output int lat, output logic [31:0] rlo, output logic [31:0] rhi,
                        output logic rdz, output logic extra_done);
    @(negedge clock);
    dividend = a; divisor_in = b; is_uns = u; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dividend = $urandom; divisor_in = $urandom; is_uns = ~u;
    lat = -1; rlo = lo; rhi = hi; rdz = 1'b0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      if (done) begin lat = k; rlo = lo; rhi = hi; rdz = div_zero; end
    end
    @(posedge clock); #1;
    extra_done = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    tests++; if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_zero); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rlo, rhi; logic rdz, xd;
    run_op(32'd7, 32'd2, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (lat !== 34) begin fails++; $display("FAIL basic_latency got %0d want 34", lat); end
    tests++; if (rlo !== 32'd3) begin fails++; $display("FAIL basic_lo got %h want 3", rlo); end
    tests++; if (rhi !== 32'd1) begin fails++; $display("FAIL basic_hi got %h want 1", rhi); end
    tests++; if (rdz !== 1'b0) begin fails++; $display("FAIL basic_dz got %b want 0", rdz); end
    tests++; if (xd !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", xd); end
    run_op(-32'sd7, 32'd2, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (rlo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL neg_a_lo got %h want fffffffd", rlo); end
    tests++; if (rhi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL neg_a_hi got %h want ffffffff", rhi); end
    run_op(32'd7, -32'sd2, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (rlo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL neg_b_lo got %h want fffffffd", rlo); end
    tests++; if (rhi !== 32'd1) begin fails++; $display("FAIL neg_b_hi got %h want 1", rhi); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] rlo, rhi; logic rdz, xd;
    run_op(32'd7, 32'd2, 1'b0, lat, rlo, rhi, rdz, xd);
    run_op(32'd5, 32'd0, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (lat !== 0) begin fails++; $display("FAIL dz_latency got %0d want 0", lat); end
    tests++; if (rdz !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", rdz); end
    tests++; if (rlo !== 32'd3) begin fails++; $display("FAIL dz_lo_kept got %h want 3", rlo); end
    tests++; if (rhi !== 32'd1) begin fails++; $display("FAIL dz_hi_kept got %h want 1", rhi); end
    tests++; if (xd !== 1'b0) begin fails++; $display("FAIL dz_done_pulse got %b want 0", xd); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] rlo, rhi; logic rdz, xd;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (rlo !== 32'h8000_0000) begin fails++; $display("FAIL ovf_lo got %h want 80000000", rlo); end
    tests++; if (rhi !== 32'd0) begin fails++; $display("FAIL ovf_hi got %h want 0", rhi); end
    tests++; if (rdz !== 1'b0) begin fails++; $display("FAIL ovf_dz got %b want 0", rdz); end
    run_op(32'd0, 32'd9, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (rlo !== 32'd0) begin fails++; $display("FAIL zero_num_lo got %h want 0", rlo); end
    tests++; if (rhi !== 32'd0) begin fails++; $display("FAIL zero_num_hi got %h want 0", rhi); end
  endtask

  task automatic test_abort();
    int lat; int ndone; logic [31:0] rlo, rhi; logic rdz, xd;
    run_op(32'd7, 32'd2, 1'b0, lat, rlo, rhi, rdz, xd);
    @(negedge clock);
    dividend = 32'd100; divisor_in = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got %b want 1", busy); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (lo !== 32'd0) begin fails++; $display("FAIL abort_lo got %h want 0", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL abort_hi got %h want 0", hi); end
    @(negedge clock); reset = 1'b0;
    ndone = 0;
    repeat (40) begin @(posedge clock); #1; if (done) ndone++; end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int ndone; int lat; logic [31:0] rlo, rhi;
    @(negedge clock);
    dividend = 32'd100; divisor_in = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0; lat = -1; rlo = '0; rhi = '0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 5) begin
        @(negedge clock); dividend = 32'd1; divisor_in = 32'd1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
      end else begin
        @(posedge clock); #1;
      end
      if (done) begin ndone++; if (lat < 0) begin lat = k; rlo = lo; rhi = hi; end end
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL b2b_done_count got %0d want 1", ndone); end
    tests++; if (lat !== 34) begin fails++; $display("FAIL b2b_latency got %0d want 34", lat); end
    tests++; if (rlo !== 32'd14) begin fails++; $display("FAIL b2b_lo got %h want e", rlo); end
    tests++; if (rhi !== 32'd2) begin fails++; $display("FAIL b2b_hi got %h want 2", rhi); end
  endtask

`ifdef DIV_UNSIGNED_EN
  task automatic test_unsigned();
    int lat; logic [31:0] rlo, rhi; logic rdz, xd;
    run_op(32'hFFFF_FFFF, 32'd2, 1'b1, lat, rlo, rhi, rdz, xd);
    tests++; if (lat !== 34) begin fails++; $display("FAIL divu_latency got %0d want 34", lat); end
    tests++; if (rlo !== 32'h7FFF_FFFF) begin fails++; $display("FAIL divu_lo got %h want 7fffffff", rlo); end
    tests++; if (rhi !== 32'd1) begin fails++; $display("FAIL divu_hi got %h want 1", rhi); end
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, lat, rlo, rhi, rdz, xd);
    tests++; if (rlo !== 32'd0) begin fails++; $display("FAIL div_s_lo got %h want 0", rlo); end
    tests++; if (rhi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_s_hi got %h want ffffffff", rhi); end
  endtask
`endif

  task automatic test_random();
    int lat; logic [31:0] rlo, rhi; logic rdz, xd;
    logic [31:0] a, b, eq, er; logic u; int sel;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
      if ($urandom_range(0, 3) == 0) a = -a;
      if (sel == 0 && i > 0) b = 32'd0;
      else if (sel < 5) begin
        b = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) b = -b;
      end else b = ($urandom == 0) ? 32'd3 : $urandom;
      if (b == 32'd0 && i == 0) b = 32'd5;
`ifdef DIV_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
`else
      u = 1'b0;
`endif
      run_op(a, b, u, lat, rlo, rhi, rdz, xd);
      if (b == 32'd0) begin
        tests++; if (lat !== 0 || rdz !== 1'b1) begin fails++; $display("FAIL rand_dz[%0d] lat %0d dz %b want 0 1", i, lat, rdz); end
        tests++; if (rlo !== mdl_lo || rhi !== mdl_hi) begin fails++; $display("FAIL rand_dz_hold[%0d] got %h/%h want %h/%h", i, rlo, rhi, mdl_lo, mdl_hi); end
      end else begin
        model(a, b, u, eq, er);
        mdl_lo = eq; mdl_hi = er;
        tests++; if (lat !== 34 || rdz !== 1'b0) begin fails++; $display("FAIL rand_lat[%0d] lat %0d dz %b want 34 0", i, lat, rdz); end
        tests++; if (rlo !== eq || rhi !== er) begin fails++; $display("FAIL rand_res[%0d] %h/%h u=%b got %h/%h want %h/%h", i, a, b, u, rlo, rhi, eq, er); end
      end
      tests++; if (xd !== 1'b0) begin fails++; $display("FAIL rand_pulse[%0d] got %b want 0", i, xd); end
    end
  endtask

  initial begin
    mdl_lo = '0; mdl_hi = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_abort();
    test_back_to_back();
`ifdef DIV_UNSIGNED_EN
    test_unsigned();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
